calcn_core: RTL and testbench

CALCN_CORE -- requirements
Module: calcn_core

---
 rtl/calcn_pkg.sv | 32 +++
 rtl/calcn_chan.sv | 101 ++++++++++
 rtl/calcn_core.sv | 139 +++++++++++++
 tb/tb_calcn_core.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcn_pkg.sv
// Shared definitions for the calcn request/response engine: command and
// response encodings, capture FSM states and the queued request entry.
package calcn_pkg;

  // Entries are sized for the widest legal configuration; narrower
  // instances zero-extend on write and slice on read.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 8;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } chan_state_t;

  typedef struct packed {
    logic [3:0]            cmd;
    logic [MAX_TAG_W-1:0]  tag;
    logic [MAX_DATA_W-1:0] op1;
    logic [MAX_DATA_W-1:0] op2;
  } entry_t;

endpackage

// File: rtl/calcn_chan.sv
// One request channel: two-cycle capture FSM (command+operand 1, then
// operand 2) feeding a small circular request queue.
module calcn_chan
  import calcn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  logic              pop,
  output logic              ready,
  output logic              valid,
  output entry_t            head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  chan_state_t state, state_next;
  logic capture, push;

  logic [3:0]        hold_cmd;
  logic [DATA_W-1:0] hold_op1;
  logic [TAG_W-1:0]  hold_tag;

  entry_t          mem [DEPTH];
  entry_t          push_entry;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (capture) state_next = ST_OP2;
      ST_OP2:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Ready is judged on pre-edge occupancy, so the entry pushed from OP2
  // always has a free slot reserved for it.
  always_comb begin
    ready   = (state == ST_IDLE) && (count < FULL);
    capture = ready && (cmd != CMD_NONE);
    push    = (state == ST_OP2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cmd <= CMD_NONE;
      hold_op1 <= '0;
      hold_tag <= '0;
    end else if (capture) begin
      hold_cmd <= cmd;
      hold_op1 <= data;
      hold_tag <= tag;
    end
  end

  always_comb begin
    push_entry     = '0;
    push_entry.cmd = hold_cmd;
    push_entry.tag = MAX_TAG_W'(hold_tag);
    push_entry.op1 = MAX_DATA_W'(hold_op1);
    push_entry.op2 = MAX_DATA_W'(data);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/calcn_core.sv
// Multi-channel calculator: per-channel capture queues share one ALU,
// granted round-robin, with a registered one-cycle response per request.
module calcn_core
  import calcn_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                           c_clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0][3:0]         req_cmd_in,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  req_data_in,
  input  logic [NUM_CH-1:0][TAG_W-1:0]   req_tag_in,
  output logic [NUM_CH-1:0]              req_ready,
  output logic [NUM_CH-1:0][1:0]         out_resp,
  output logic [NUM_CH-1:0][DATA_W-1:0]  out_data,
  output logic [NUM_CH-1:0][TAG_W-1:0]   out_tag
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = $clog2(DATA_W);

  logic [NUM_CH-1:0] chan_valid;
  entry_t            chan_head [NUM_CH];

  logic [CW-1:0] rr_ptr, grant_ch;
  logic          grant_valid;
  int            idx;

  logic          sel_valid;
  logic [CW-1:0] sel_ch;
  entry_t        sel_entry;

  logic [DATA_W-1:0] op_a, op_b, alu_data;
  logic [DATA_W:0]   sum;
  logic [1:0]        alu_resp;
  logic              unused_entry;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    calcn_chan #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk   (c_clk),
      .rst_n (reset),
      .cmd   (req_cmd_in[c]),
      .data  (req_data_in[c]),
      .tag   (req_tag_in[c]),
      .pop   (grant_valid && (grant_ch == CW'(c))),
      .ready (req_ready[c]),
      .valid (chan_valid[c]),
      .head  (chan_head[c])
    );
  end

  // Search starts at rr_ptr, which always points one past the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_valid && chan_valid[idx]) begin
        grant_valid = 1'b1;
        grant_ch    = CW'(idx);
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      sel_valid <= 1'b0;
      sel_ch    <= '0;
      sel_entry <= '0;
    end else begin
      sel_valid <= grant_valid;
      if (grant_valid) begin
        sel_ch    <= grant_ch;
        sel_entry <= chan_head[grant_ch];
        rr_ptr    <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
      end
    end
  end

  assign op_a         = sel_entry.op1[DATA_W-1:0];
  assign op_b         = sel_entry.op2[DATA_W-1:0];
  assign unused_entry = ^{sel_entry.op1, sel_entry.op2, sel_entry.tag};

  always_comb begin
    sum      = {1'b0, op_a} + {1'b0, op_b};
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (sel_entry.cmd)
      CMD_ADD: if (!sum[DATA_W]) begin
        alu_resp = RESP_OK;
        alu_data = sum[DATA_W-1:0];
      end
      CMD_SUB: if (op_b <= op_a) begin
        alu_resp = RESP_OK;
        alu_data = op_a - op_b;
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = op_a << op_b[SW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = op_a >> op_b[SW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel_valid && (sel_ch == CW'(c))) begin
          out_resp[c] <= alu_resp;
          out_data[c] <= alu_data;
          out_tag[c]  <= sel_entry.tag[TAG_W-1:0];
        end else begin
          out_resp[c] <= RESP_NONE;
          out_data[c] <= '0;
          out_tag[c]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_calcn_core.sv
// Scoreboard bench for calcn_core: a transaction-level model predicts
// acceptance, arbitration order and results; a monitor checks each response.
module tb_calcn_core;
  import calcn_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 4;

  logic c_clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0][3:0]        req_cmd_in;
  logic [NUM_CH-1:0][DATA_W-1:0] req_data_in;
  logic [NUM_CH-1:0][TAG_W-1:0]  req_tag_in;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0][1:0]        out_resp;
  logic [NUM_CH-1:0][DATA_W-1:0] out_data;
  logic [NUM_CH-1:0][TAG_W-1:0]  out_tag;

  logic [0:0][3:0] s_cmd;
  logic [0:0][7:0] s_data;
  logic [0:0][1:0] s_tag;
  logic [0:0]      s_ready;
  logic [0:0][1:0] s_resp;
  logic [0:0][7:0] s_out;
  logic [0:0][1:0] s_otag;

  calcn_core #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
  );

  calcn_core #(.NUM_CH(1), .DATA_W(8), .TAG_W(2), .DEPTH(2)) dut8 (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(s_cmd), .req_data_in(s_data), .req_tag_in(s_tag),
    .req_ready(s_ready), .out_resp(s_resp), .out_data(s_out), .out_tag(s_otag)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } exp_t;

  int total = 0;
  int bad   = 0;

  req_t script [NUM_CH][$];
  req_t m_q    [NUM_CH][$];
  exp_t exp_q  [NUM_CH][$];
  bit   m_phase [NUM_CH];
  bit   m_rdy   [NUM_CH];
  req_t m_hold  [NUM_CH];
  int   m_rr;
  bit   m_pv;
  int   m_pch;
  req_t m_pe;
  int   cyc = 0;
  logic [1:0]      mr;
  longint unsigned md;
  logic [DATA_W-1:0] drv_op2 [NUM_CH];
  req_t drv_r;
  exp_t mon_e;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input string act, input string exp);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=%s expected=%s (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arithmetic straight from the command definitions
  function automatic void ref_calc(input logic [3:0] cmd, input longint unsigned a,
                                   input longint unsigned b, output logic [1:0] resp,
                                   output longint unsigned d);
    longint unsigned mask;
    mask = (64'd1 << DATA_W) - 64'd1;
    resp = 2'd2;
    d    = 0;
    case (cmd)
      4'd1: if (a + b <= mask) begin resp = 2'd1; d = a + b; end
      4'd2: if (b <= a) begin resp = 2'd1; d = a - b; end
      4'd5: begin resp = 2'd1; d = (a << (b % DATA_W)) & mask; end
      4'd6: begin resp = 2'd1; d = a >> (b % DATA_W); end
      default: ;
    endcase
  endfunction

  function automatic bit m_ready(input int c);
    return !m_phase[c] && (m_q[c].size() < DEPTH);
  endfunction

  // Transaction model: one shared server, round-robin over non-empty queues
  always @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_q[c].delete();
        exp_q[c].delete();
        m_phase[c] = 1'b0;
      end
      m_rr = 0;
      m_pv = 1'b0;
    end else begin
      cyc++;
      for (int c = 0; c < NUM_CH; c++) m_rdy[c] = m_ready(c);
      if (m_pv) begin
        ref_calc(m_pe.cmd, longint'(m_pe.op1), longint'(m_pe.op2), mr, md);
        exp_q[m_pch].push_back('{resp: mr, data: DATA_W'(md), tag: m_pe.tag, cyc: cyc});
      end
      m_pv = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!m_pv && m_q[(m_rr + i) % NUM_CH].size() > 0) begin
          m_pch = (m_rr + i) % NUM_CH;
          m_pe  = m_q[m_pch].pop_front();
          m_pv  = 1'b1;
        end
      end
      if (m_pv) m_rr = (m_pch + 1) % NUM_CH;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_phase[c]) begin
          m_hold[c].op2 = req_data_in[c];
          m_q[c].push_back(m_hold[c]);
          m_phase[c] = 1'b0;
        end else if (req_cmd_in[c] != 4'd0 && m_rdy[c]) begin
          m_hold[c] = '{cmd: req_cmd_in[c], op1: req_data_in[c], op2: '0, tag: req_tag_in[c]};
          m_phase[c] = 1'b1;
        end
      end
    end
  end

  // Driver: presents scripted requests; junk commands during operand-2 cycles
  initial begin
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    forever begin
      @(posedge c_clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_phase[c]) begin
          req_cmd_in[c]  = 4'($urandom);
          req_data_in[c] = drv_op2[c];
          req_tag_in[c]  = TAG_W'($urandom);
        end else if (reset && script[c].size() > 0) begin
          drv_r          = script[c].pop_front();
          req_cmd_in[c]  = drv_r.cmd;
          req_data_in[c] = drv_r.op1;
          req_tag_in[c]  = drv_r.tag;
          drv_op2[c]     = drv_r.op2;
        end else begin
          req_cmd_in[c]  = 4'd0;
          req_data_in[c] = DATA_W'($urandom);
          req_tag_in[c]  = TAG_W'($urandom);
        end
      end
    end
  end

  // Monitor: pops the per-channel scoreboard whenever a response shows up
  always @(negedge c_clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        check_output("reset_out", {out_resp[c], out_tag[c], out_data[c]}, '0);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        check_output($sformatf("ready_ch%0d", c), req_ready[c], m_ready(c));
        while (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
          mon_e = exp_q[c].pop_front();
          note_fail($sformatf("missing_ch%0d", c), "none", $sformatf("resp@%0d", mon_e.cyc));
        end
        if (out_resp[c] != 2'd0) begin
          if (exp_q[c].size() == 0) begin
            note_fail($sformatf("unexpected_ch%0d", c), $sformatf("resp=%0d", out_resp[c]), "none");
          end else begin
            mon_e = exp_q[c].pop_front();
            check_output($sformatf("resp_ch%0d", c), out_resp[c], mon_e.resp);
            check_output($sformatf("data_ch%0d", c), out_data[c], mon_e.data);
            check_output($sformatf("tag_ch%0d", c), out_tag[c], mon_e.tag);
            check_output($sformatf("cycle_ch%0d", c), cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input int ch, input logic [3:0] cmd, input logic [DATA_W-1:0] op1,
                                input logic [DATA_W-1:0] op2, input logic [TAG_W-1:0] tag);
    script[ch].push_back('{cmd: cmd, op1: op1, op2: op2, tag: tag});
  endtask

  task automatic wait_drain(input int max_cyc);
    bit idle;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge c_clk);
      #1;
      idle = !m_pv;
      for (int c = 0; c < NUM_CH; c++)
        if (script[c].size() > 0 || m_q[c].size() > 0 || exp_q[c].size() > 0 || m_phase[c])
          idle = 1'b0;
      if (idle) return;
    end
    note_fail("drain_timeout", "busy", "idle");
  endtask

  function automatic logic [DATA_W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return DATA_W'($urandom_range(0, 40));
      1:       return '1 - DATA_W'($urandom_range(0, 15));
      default: return DATA_W'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rnd_cmd();
    case ($urandom_range(0, 9))
      0, 1:    return CMD_ADD;
      2, 3:    return CMD_SUB;
      4, 5:    return CMD_SHL;
      6, 7:    return CMD_SHR;
      8:       return 4'($urandom_range(3, 4));
      default: return 4'($urandom_range(7, 15));
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    s_cmd  = '0;
    s_data = '0;
    s_tag  = '0;
    #3 reset = 1'b0;
    repeat (3) @(negedge c_clk);
    @(posedge c_clk);
    #2 reset = 1'b1;

    apply_stimulus(0, CMD_ADD, 32'h5, 32'h7, 2'd2);
    wait_drain(50);

    apply_stimulus(1, CMD_ADD, 32'hFFFF_FFFF, 32'h1, 2'd1);
    apply_stimulus(2, CMD_SUB, 32'h3, 32'h5, 2'd3);
    apply_stimulus(3, 4'h9, 32'h10, 32'h20, 2'd0);
    wait_drain(50);

    for (int c = 0; c < NUM_CH; c++) apply_stimulus(c, CMD_SHL, 32'h1, 32'h24, TAG_W'(c));
    wait_drain(50);

    // ch0 outpaces its share of the ALU, so its queue fills and commands drop
    for (int i = 0; i < 3 * DEPTH; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        apply_stimulus(c, (c == 0) ? CMD_ADD : rnd_cmd(), rnd_operand(), rnd_operand(), TAG_W'(i));
    end
    wait_drain(500);

    apply_stimulus(0, CMD_ADD, 32'h1, 32'h2, 2'd1);
    for (int i = 0; i < 10 && !m_phase[0]; i++) begin
      @(posedge c_clk);
      #2;
    end
    if (!m_phase[0]) note_fail("rst_capture", "idle", "op2");
    reset = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++)
      check_output("rst_imm", {out_resp[c], out_tag[c], out_data[c]}, '0);
    repeat (2) @(negedge c_clk);
    @(posedge c_clk);
    #2 reset = 1'b1;
    wait_drain(20);
    repeat (8) @(negedge c_clk);

    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 50; i++)
        apply_stimulus($urandom_range(0, NUM_CH - 1), rnd_cmd(), rnd_operand(), rnd_operand(),
                       TAG_W'($urandom));
      wait_drain(600);
    end

    check_output("s8_ready", s_ready[0], 1'b1);
    @(posedge c_clk);
    #1;
    s_cmd[0]  = CMD_SHR;
    s_data[0] = 8'h80;
    s_tag[0]  = 2'd1;
    @(posedge c_clk);
    #1;
    s_cmd[0]  = 4'h0;
    s_data[0] = 8'h0F;
    @(posedge c_clk);
    #1;
    s_data[0] = 8'h00;
    @(negedge c_clk);
    check_output("s8_e0", {s_resp[0], s_otag[0], s_out[0]}, '0);
    @(negedge c_clk);
    check_output("s8_e1", {s_resp[0], s_otag[0], s_out[0]}, '0);
    @(negedge c_clk);
    check_output("s8_resp", s_resp[0], 2'd1);
    check_output("s8_data", s_out[0], 8'h01);
    check_output("s8_tag", s_otag[0], 2'd1);
    @(negedge c_clk);
    check_output("s8_e3", {s_resp[0], s_otag[0], s_out[0]}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
